// File: rtl/apb_fsm_controller_if.sv
// Bus bundle between the AHB slave stage, the APB master FSM and the APB interface stage.
// The master modport is the FSM's view; the slave modport is the surrounding bridge's view.
interface apb_fsm_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
);
  logic              valid;
  logic              Hwrite;
  logic              Hwritereg;
  logic [ADDR_W-1:0] Haddr1;
  logic [ADDR_W-1:0] Haddr2;
  logic [DATA_W-1:0] Hwdata;
  logic [SEL_W-1:0]  tempselx;
  logic [DATA_W-1:0] Prdata;

  logic              Pwrite;
  logic              Penable;
  logic [SEL_W-1:0]  Pselx;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;

  modport master (
    input  valid, Hwrite, Hwritereg, Haddr1, Haddr2, Hwdata, tempselx, Prdata,
    output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata
  );

  modport slave (
    output valid, Hwrite, Hwritereg, Haddr1, Haddr2, Hwdata, tempselx, Prdata,
    input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata
  );
endinterface

// File: rtl/apb_fsm_controller.sv
// APB master state machine of the AHB-to-APB bridge: sequences SETUP/ACCESS phases,
// including the write-data wait and pipelined back-to-back writes.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
) (
  input logic                 Hclk,
  input logic                 Hreset,
  apb_fsm_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  state_t            state_r;
  state_t            state_s;

  logic              pwrite_r,    pwrite_s;
  logic              penable_r,   penable_s;
  logic [SEL_W-1:0]  pselx_r,     pselx_s;
  logic [ADDR_W-1:0] paddr_r,     paddr_s;
  logic [DATA_W-1:0] pwdata_r,    pwdata_s;
  logic              hreadyout_r, hreadyout_s;
  logic [DATA_W-1:0] hrdata_r,    hrdata_s;

  // State and output registers; outputs load from next-state decode on the same edge.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_r     <= ST_IDLE;
      pwrite_r    <= 1'b0;
      penable_r   <= 1'b0;
      pselx_r     <= {SEL_W{1'b0}};
      paddr_r     <= {ADDR_W{1'b0}};
      pwdata_r    <= {DATA_W{1'b0}};
      hreadyout_r <= 1'b1;
      hrdata_r    <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      pwrite_r    <= pwrite_s;
      penable_r   <= penable_s;
      pselx_r     <= pselx_s;
      paddr_r     <= paddr_s;
      pwdata_r    <= pwdata_s;
      hreadyout_r <= hreadyout_s;
      hrdata_r    <= hrdata_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (!bus.valid)      state_s = ST_IDLE;
        else if (bus.Hwrite) state_s = ST_WWAIT;
        else                 state_s = ST_READ;
      end
      ST_WWAIT: begin
        if (bus.valid) state_s = ST_WRITEP;
        else           state_s = ST_WRITE;
      end
      ST_READ:   state_s = ST_RENABLE;
      ST_WRITE: begin
        if (bus.valid) state_s = ST_WENABLEP;
        else           state_s = ST_WENABLE;
      end
      ST_WRITEP: state_s = ST_WENABLEP;
      ST_RENABLE, ST_WENABLE: begin
        if (!bus.valid)      state_s = ST_IDLE;
        else if (bus.Hwrite) state_s = ST_WWAIT;
        else                 state_s = ST_READ;
      end
      ST_WENABLEP: begin
        // The pipelined write's direction tells whether the queued transfer is a read.
        if (!bus.Hwritereg) state_s = ST_READ;
        else if (bus.valid) state_s = ST_WRITEP;
        else                state_s = ST_WRITE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output register load values, selected by the state being entered.
  always_comb begin
    pwrite_s    = pwrite_r;
    penable_s   = penable_r;
    pselx_s     = pselx_r;
    paddr_s     = paddr_r;
    pwdata_s    = pwdata_r;
    hreadyout_s = hreadyout_r;
    if (state_r == ST_RENABLE) hrdata_s = bus.Prdata;
    else                       hrdata_s = hrdata_r;

    case (state_s)
      ST_READ: begin
        paddr_s     = bus.Haddr1;
        pwrite_s    = 1'b0;
        pselx_s     = bus.tempselx;
        penable_s   = 1'b0;
        hreadyout_s = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        // Write address is the delayed copy so it lines up with the data phase.
        paddr_s     = bus.Haddr2;
        pwdata_s    = bus.Hwdata;
        pwrite_s    = 1'b1;
        pselx_s     = bus.tempselx;
        penable_s   = 1'b0;
        hreadyout_s = 1'b0;
      end
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
        penable_s   = 1'b1;
        hreadyout_s = 1'b1;
      end
      ST_IDLE, ST_WWAIT: begin
        pselx_s     = {SEL_W{1'b0}};
        penable_s   = 1'b0;
        hreadyout_s = 1'b1;
      end
      default: begin
        pselx_s     = {SEL_W{1'b0}};
        penable_s   = 1'b0;
        hreadyout_s = 1'b1;
      end
    endcase
  end

  assign bus.Pwrite    = pwrite_r;
  assign bus.Penable   = penable_r;
  assign bus.Pselx     = pselx_r;
  assign bus.Paddr     = paddr_r;
  assign bus.Pwdata    = pwdata_r;
  assign bus.Hreadyout = hreadyout_r;
  assign bus.Hrdata    = hrdata_r;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: stimulus queues expected APB phases and read data,
// a negedge monitor pops and compares whenever the DUT presents a phase.
module tb_apb_fsm_controller;

  logic Hclk;
  logic Hreset;

  apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) bus ();

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // AHB-stage pipeline copies: address and direction delayed one cycle.
  always @(posedge Hclk) begin
    bus.Haddr2    <= bus.Haddr1;
    bus.Hwritereg <= bus.Hwrite;
  end

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        en;
    logic        rdy;
  } phase_t;

  phase_t      exp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic        prev_rd_access = 1'b0;
  phase_t      e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_setup(input logic [2:0] sel, input logic [31:0] addr,
                            input logic wr, input logic [31:0] wdata);
    exp_q.push_back('{sel: sel, addr: addr, wr: wr, wdata: wdata, en: 1'b0, rdy: 1'b0});
  endtask

  task automatic push_xfer(input logic [2:0] sel, input logic [31:0] addr,
                           input logic wr, input logic [31:0] wdata);
    push_setup(sel, addr, wr, wdata);
    exp_q.push_back('{sel: sel, addr: addr, wr: wr, wdata: wdata, en: 1'b1, rdy: 1'b1});
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.valid  = 1'b0;
    bus.Hwrite = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor: every selected cycle is an APB phase and must match the next queued one.
  always @(negedge Hclk) begin
    if (mon_en) begin
      if (bus.Pselx != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_phase_sel", {29'd0, bus.Pselx}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ph_sel",     {29'd0, bus.Pselx},     {29'd0, e.sel});
          chk("ph_addr",    bus.Paddr,              e.addr);
          chk("ph_write",   {31'd0, bus.Pwrite},    {31'd0, e.wr});
          chk("ph_wdata",   bus.Pwdata,             e.wdata);
          chk("ph_enable",  {31'd0, bus.Penable},   {31'd0, e.en});
          chk("ph_hready",  {31'd0, bus.Hreadyout}, {31'd0, e.rdy});
        end
      end else begin
        chk("idle_enable", {31'd0, bus.Penable},   32'd0);
        chk("idle_hready", {31'd0, bus.Hreadyout}, 32'd1);
      end
      if (prev_rd_access) begin
        if (rd_q.size() == 0) chk("unexpected_rdata_q", 32'd1, {31'd0, prev_rd_access} - 32'd1);
        else                  chk("hrdata", bus.Hrdata, rd_q.pop_front());
      end
      prev_rd_access = bus.Penable && !bus.Pwrite;
    end else begin
      prev_rd_access = 1'b0;
    end
  end

  initial begin
    Hreset        = 1'b1;
    bus.valid     = 1'b1;
    bus.Hwrite    = 1'b0;
    bus.Haddr1    = 32'h8000_0000;
    bus.Hwdata    = 32'h0;
    bus.tempselx  = 3'b001;
    bus.Prdata    = 32'h0;
    bus.Haddr2    = 32'h0;
    bus.Hwritereg = 1'b0;

    // Reset held two edges with valid asserted.
    tick();
    tick();
    chk("rst_pselx",  {29'd0, bus.Pselx},     32'd0);
    chk("rst_penable",{31'd0, bus.Penable},   32'd0);
    chk("rst_hready", {31'd0, bus.Hreadyout}, 32'd1);
    chk("rst_hrdata", bus.Hrdata,             32'd0);
    chk("rst_paddr",  bus.Paddr,              32'd0);
    chk("rst_pwdata", bus.Pwdata,             32'd0);
    chk("rst_pwrite", {31'd0, bus.Pwrite},    32'd0);
    Hreset    = 1'b0;
    bus.valid = 1'b0;
    mon_en    = 1'b1;
    idle_cycles(2);

    // Single read.
    push_xfer(3'b001, 32'h8000_0004, 1'b0, 32'h0);
    rd_q.push_back(32'd25);
    bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr1 = 32'h8000_0004;
    bus.tempselx = 3'b001; bus.Prdata = 32'd25;
    tick();
    idle_cycles(4);

    // Back-to-back reads: second issued from RENABLE.
    push_xfer(3'b010, 32'h8000_0020, 1'b0, 32'h0);
    push_xfer(3'b010, 32'h8000_0024, 1'b0, 32'h0);
    rd_q.push_back(32'h0000_0011);
    rd_q.push_back(32'h0000_0022);
    bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr1 = 32'h8000_0020;
    bus.tempselx = 3'b010; bus.Prdata = 32'h0000_0011;
    tick();
    bus.valid = 1'b0;
    tick();
    bus.valid = 1'b1; bus.Haddr1 = 32'h8000_0024;
    tick();
    bus.valid = 1'b0; bus.Prdata = 32'h0000_0022;
    tick();
    idle_cycles(3);

    // Single write through WWAIT -> WRITE -> WENABLE.
    push_xfer(3'b010, 32'h8400_0010, 1'b1, 32'hDEAD_BEEF);
    bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr1 = 32'h8400_0010; bus.tempselx = 3'b010;
    tick();
    bus.valid = 1'b0; bus.Hwrite = 1'b0; bus.Hwdata = 32'hDEAD_BEEF;
    tick();
    tick();
    idle_cycles(3);

    // Three pipelined writes; address held during the non-ready cycles.
    push_xfer(3'b100, 32'h8400_0100, 1'b1, 32'h1111_0001);
    push_xfer(3'b100, 32'h8400_0104, 1'b1, 32'h2222_0002);
    push_xfer(3'b100, 32'h8400_0108, 1'b1, 32'h3333_0003);
    bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.tempselx = 3'b100; bus.Haddr1 = 32'h8400_0100;
    tick();
    bus.Haddr1 = 32'h8400_0104; bus.Hwdata = 32'h1111_0001;
    tick();
    tick();
    bus.Haddr1 = 32'h8400_0108; bus.Hwdata = 32'h2222_0002;
    tick();
    tick();
    bus.valid = 1'b0; bus.Hwrite = 1'b0; bus.Hwdata = 32'h3333_0003;
    tick();
    tick();
    idle_cycles(3);

    // Write followed by read: WENABLEP with Hwritereg low goes to READ.
    push_xfer(3'b001, 32'h8800_0040, 1'b1, 32'hCAFE_F00D);
    push_xfer(3'b001, 32'h8800_0044, 1'b0, 32'hCAFE_F00D);
    rd_q.push_back(32'h1234_5678);
    bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr1 = 32'h8800_0040; bus.tempselx = 3'b001;
    tick();
    bus.Hwrite = 1'b0; bus.Haddr1 = 32'h8800_0044; bus.Hwdata = 32'hCAFE_F00D;
    tick();
    tick();
    bus.valid = 1'b0; bus.Prdata = 32'h1234_5678;
    tick();
    tick();
    idle_cycles(3);

    // Reset while in WRITE: the ACCESS phase must never appear.
    bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr1 = 32'h8400_0200; bus.tempselx = 3'b010;
    tick();
    push_setup(3'b010, 32'h8400_0200, 1'b1, 32'h5555_AAAA);
    bus.valid = 1'b0; bus.Hwrite = 1'b0; bus.Hwdata = 32'h5555_AAAA;
    tick();
    Hreset = 1'b1;
    tick();
    chk("midrst_penable", {31'd0, bus.Penable},   32'd0);
    chk("midrst_pselx",   {29'd0, bus.Pselx},     32'd0);
    chk("midrst_hready",  {31'd0, bus.Hreadyout}, 32'd1);
    chk("midrst_pwdata",  bus.Pwdata,             32'd0);
    chk("midrst_hrdata",  bus.Hrdata,             32'd0);

    // Read after reset completes normally.
    Hreset = 1'b0;
    push_xfer(3'b100, 32'h8000_0008, 1'b0, 32'h0);
    rd_q.push_back(32'hA5A5_5A5A);
    bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr1 = 32'h8000_0008;
    bus.tempselx = 3'b100; bus.Prdata = 32'hA5A5_5A5A;
    tick();
    idle_cycles(5);

    chk("phase_q_left", exp_q.size(), 32'd0);
    chk("rdata_q_left", rd_q.size(),  32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- Bridge-side APB master state machine of the AHB-to-APB bridge.
- Consumes the pipelined AHB transfer qualifiers from the AHB slave stage.
- Drives Pwrite/Pselx/Penable/Paddr/Pwdata into the APB interface stage, and returns Hreadyout plus captured read data to the AHB side.
- Enforces APB SETUP→ACCESS sequencing, including one-cycle write-data wait and pipelined back-to-back writes.

Parameters:
ADDR_W, 32, width of Haddr1/Haddr2/Paddr
DATA_W, 32, width of Hwdata/Pwdata/Prdata/Hrdata
SEL_W, 3, width of tempselx/Pselx (one-hot peripheral select)

Ports:
Hclk  in  1  bridge clock; all state changes on rising edge
Hreset  in  1  synchronous, active-high reset
valid  in  1  AHB stage holds a valid NONSEQ/SEQ transfer to a mapped slave this cycle
Hwrite  in  1  direction of current AHB address phase (1=write)
Hwritereg  in  1  Hwrite delayed one cycle (direction of previous transfer)
Haddr1  in  ADDR_W  current-cycle registered AHB address
Haddr2  in  ADDR_W  Haddr1 delayed one cycle (aligned with Hwdata)
Hwdata  in  DATA_W  AHB write data (data phase)
tempselx  in  SEL_W  one-hot select decoded from current address
Prdata  in  DATA_W  read data from APB interface stage
Pwrite  out  1  APB direction
Penable  out  1  APB ACCESS phase strobe
Pselx  out  SEL_W  APB peripheral select
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Hreadyout  out  1  1 = bridge can accept next AHB transfer
Hrdata  out  DATA_W  read data returned to AHB

Behaviour:
- Reset (Hreset=1 at edge): state=ST_IDLE; Pwrite=0, Penable=0, Pselx=0, Paddr=0, Pwdata=0, Hrdata=0, Hreadyout=1. Reset wins over any transition, including mid-transfer; Pselx/Penable deassert the cycle after reset is sampled.
- All outputs are registered. Output values are computed from the next state and load on the same edge as the state register, so outputs reflect the state they belong to with zero extra latency.
- States and transitions:
  - ST_IDLE: !valid→ST_IDLE; valid&Hwrite→ST_WWAIT; valid&!Hwrite→ST_READ.
  - ST_WWAIT: !valid→ST_WRITE; valid→ST_WRITEP.
  - ST_READ: →ST_RENABLE (unconditional).
  - ST_WRITE: !valid→ST_WENABLE; valid→ST_WENABLEP.
  - ST_WRITEP: →ST_WENABLEP.
  - ST_RENABLE, ST_WENABLE: !valid→ST_IDLE; valid&!Hwrite→ST_READ; valid&Hwrite→ST_WWAIT.
  - ST_WENABLEP: !Hwritereg→ST_READ; Hwritereg&!valid→ST_WRITE; Hwritereg&valid→ST_WRITEP.
- Output loads by next state:
  - ST_READ: Paddr←Haddr1; Pwrite←0; Pselx←tempselx; Penable←0; Hreadyout←0.
  - ST_WRITE, ST_WRITEP: Paddr←Haddr2; Pwdata←Hwdata; Pwrite←1; Pselx←tempselx; Penable←0; Hreadyout←0.
  - ST_RENABLE, ST_WENABLE, ST_WENABLEP: Penable←1; Paddr, Pwdata, Pwrite and Pselx hold; Hreadyout←1.
  - ST_IDLE, ST_WWAIT: Pselx←0; Penable←0; Hreadyout←1; Paddr, Pwdata and Pwrite hold.
- Hrdata←Prdata on the edge leaving ST_RENABLE, i.e. when state==ST_RENABLE. Hrdata holds at all other times.
- SETUP is always exactly 1 cycle and ACCESS exactly 1 cycle; there is no PREADY wait.
- Penable=1 never occurs without Pselx≠0.
- Every ACCESS cycle is preceded by a SETUP cycle with the same Paddr/Pselx/Pwrite.
- Unreachable/illegal state encodings return to ST_IDLE on the next edge, with ST_IDLE output loads.
- Single read latency: valid sampled → SETUP next cycle → ACCESS the cycle after → Hrdata valid the following cycle.

Test Plan:
- Reset: assert Hreset 2 cycles with valid=1 → Pselx=0, Penable=0, Hreadyout=1, Hrdata=0, state ST_IDLE.
- Single read: valid=1, Hwrite=0, Haddr1=0x8000_0004, tempselx=3'b001 for 1 cycle, Prdata=25.
  - Cycle+1: Pselx=001, Paddr=0x8000_0004, Pwrite=0, Penable=0, Hreadyout=0.
  - Cycle+2: Penable=1, Hreadyout=1.
  - Cycle+3: Hrdata=25, Pselx=0.
- Single write: valid=1, Hwrite=1 then valid=0; Haddr2=0x8400_0010; Hwdata=0xDEAD_BEEF in the WWAIT→WRITE cycle.
  - SETUP: Pwrite=1, Paddr=0x8400_0010, Pwdata=0xDEAD_BEEF.
  - ACCESS: Penable=1.
  - Then return to IDLE.
- Back-to-back writes: valid=1, Hwrite=1 for 3 transfers → state sequence WWAIT, WRITEP, WENABLEP, WRITEP, WENABLEP…; each Pwdata equals the matching Hwdata; Penable alternates 0/1.
- Write followed by read: Hwritereg=1 into WENABLEP, then Hwritereg=0 → READ, then RENABLE with Pwrite=0; Hrdata=Prdata.
- Reset mid-transfer: assert Hreset while in ST_WRITE → next cycle Penable=0, Pselx=0, Hreadyout=1; a new read afterwards completes normally.
